// File: rtl/multiplier_pkg.sv
// Datapath control types shared by the multiplier/reduction blocks.
package multiplier_pkg;
    typedef enum logic [1:0] {
        SCHED_RUN    = 2'd0,
        SCHED_DRAIN  = 2'd1,
        SCHED_HALTED = 2'd2
    } sched_state_e;
endpackage

// File: rtl/params_pkg.sv
// Shared datapath parameters: reduction modulus constants and scheduler defaults.
package params_pkg;
    localparam int DATA_LENGTH = 32;
    localparam logic [DATA_LENGTH-1:0] MODULUS        = 32'h007F_E001;
    localparam logic [DATA_LENGTH-1:0] MODULUS_LENGTH = 32'd23;
    // floor(2^(2*23) / MODULUS)
    localparam logic [DATA_LENGTH-1:0] MU             = 32'h0080_2007;

    localparam int NUM_REQ       = 4;
    localparam int SCHED_LATENCY = 5;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, priority starts after the last accepted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req,
    input  logic                 accept,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] last;
    logic          found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       last <= IW'(N-1);
        else if (accept) last <= idx;
    end

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(last) + i) % N]) begin
                found                      = 1'b1;
                grant[(int'(last) + i) % N] = 1'b1;
                idx                        = IW'((int'(last) + i) % N);
            end
        end
        if (!enable) grant = '0;
    end
endmodule

// File: rtl/barrett_sched.sv
// Shares one pipelined Barrett reduction unit among NUM_REQ requesters with ID tagging and drain.
// Optional protocol checker enabled by defining BARRETT_SCHED_CHECK_EN.
module barrett_sched
    import multiplier_pkg::*;
#(
    parameter int NUM_REQ = params_pkg::NUM_REQ,
    parameter int LATENCY = params_pkg::SCHED_LATENCY
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [NUM_REQ-1:0]                                req_valid_i,
    input  logic [NUM_REQ-1:0][params_pkg::DATA_LENGTH-1:0]   req_x_i,
    output logic [NUM_REQ-1:0]                                req_ready_o,
    output logic [NUM_REQ-1:0]                                resp_valid_o,
    output logic [params_pkg::DATA_LENGTH-1:0]                resp_r_o,
    output logic                                              bu_start_o,
    output logic [params_pkg::DATA_LENGTH-1:0]                bu_x_o,
    output logic [params_pkg::DATA_LENGTH-1:0]                bu_q_o,
    output logic [params_pkg::DATA_LENGTH-1:0]                bu_q_bl_o,
    output logic [params_pkg::DATA_LENGTH-1:0]                bu_mu_o,
    input  logic [params_pkg::DATA_LENGTH-1:0]                bu_result_i,
    input  logic                                              bu_valid_i,
    input  logic                                              drain_i,
    output logic                                              drained_o,
    output logic                                              err_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LATENCY + 2);

    localparam logic [1:0] S_RUN    = SCHED_RUN;
    localparam logic [1:0] S_DRAIN  = SCHED_DRAIN;
    localparam logic [1:0] S_HALTED = SCHED_HALTED;

    logic [1:0]                    state;
    logic [NUM_REQ-1:0]            grant;
    logic [IW-1:0]                 gnt_idx;
    logic [IW-1:0]                 iss_id;
    logic                          accept;
    logic                          arb_en;
    logic [LATENCY-1:0]            vld_pipe;
    logic [LATENCY-1:0][IW-1:0]    id_pipe;
    logic [CW-1:0]                 inflight;
    logic                          tail_vld;
    logic [IW-1:0]                 tail_id;

    // Gating on drain_i directly makes ready drop in the same cycle drain is raised.
    assign arb_en = (state == S_RUN) && !drain_i && !rst_i;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    (req_valid_i),
        .accept (accept),
        .enable (arb_en),
        .grant  (grant),
        .idx    (gnt_idx)
    );

    assign req_ready_o = grant;
    assign accept      = |(req_valid_i & grant);

    assign bu_q_o    = params_pkg::MODULUS;
    assign bu_q_bl_o = params_pkg::MODULUS_LENGTH;
    assign bu_mu_o   = params_pkg::MU;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bu_start_o <= 1'b0;
            bu_x_o     <= '0;
            iss_id     <= '0;
        end else begin
            bu_start_o <= accept;
            if (accept) begin
                bu_x_o <= req_x_i[gnt_idx];
                iss_id <= gnt_idx;
            end
        end
    end

    // Tag line depth equals unit latency so the tail lines up with bu_valid_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= bu_start_o;
            id_pipe[0]  <= iss_id;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign tail_vld = vld_pipe[LATENCY-1];
    assign tail_id  = id_pipe[LATENCY-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= '0;
        end else begin
            case ({bu_start_o, tail_vld})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_RUN;
        end else begin
            case (state)
                S_RUN:    if (drain_i) state <= S_DRAIN;
                S_DRAIN:  if (inflight == '0 && !bu_start_o) state <= S_HALTED;
                S_HALTED: if (!drain_i) state <= S_RUN;
                default:  state <= S_RUN;
            endcase
        end
    end

    assign drained_o = (state == S_HALTED);

    always_comb begin
        resp_valid_o = '0;
        if (tail_vld) resp_valid_o[tail_id] = 1'b1;
    end

    assign resp_r_o = bu_result_i;

`ifdef BARRETT_SCHED_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else if ((bu_valid_i != tail_vld) ||
                 (tail_vld && (bu_result_i >= params_pkg::MODULUS)))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    logic unused_bu_valid;
    assign unused_bu_valid = bu_valid_i;
    assign err_o           = 1'b0;
`endif
endmodule

// File: tb/tb_barrett_sched.sv
// Directed bench for barrett_sched with a behavioural LATENCY-deep reduction unit model.
module tb_barrett_sched;
    localparam int NR  = 4;
    localparam int LAT = 5;
    localparam logic [31:0] Q = 32'h007F_E001;
`ifdef BARRETT_SCHED_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][31:0]  req_x;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        resp_valid;
    logic [31:0]          resp_r;
    logic                 bu_start;
    logic [31:0]          bu_x, bu_q, bu_q_bl, bu_mu;
    logic [31:0]          bu_result;
    logic                 bu_valid;
    logic                 drain;
    logic                 drained;
    logic                 err;
    logic                 spur;

    always #5 clk = ~clk;

    barrett_sched #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_x_i      (req_x),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_r_o     (resp_r),
        .bu_start_o   (bu_start),
        .bu_x_o       (bu_x),
        .bu_q_o       (bu_q),
        .bu_q_bl_o    (bu_q_bl),
        .bu_mu_o      (bu_mu),
        .bu_result_i  (bu_result),
        .bu_valid_i   (bu_valid),
        .drain_i      (drain),
        .drained_o    (drained),
        .err_o        (err)
    );

    // Reduction unit model: result appears LAT cycles after start.
    logic [LAT-1:0]       m_vld = '0;
    logic [LAT-1:0][31:0] m_r   = '0;
    always @(posedge clk) begin
`ifdef BARRETT_SCHED_CHECK_EN
        if (rst) m_vld <= '0;
        else
`endif
        begin
            m_vld <= {m_vld[LAT-2:0], bu_start};
            m_r   <= {m_r[LAT-2:0], bu_x % Q};
        end
    end
    assign bu_valid  = m_vld[LAT-1] | spur;
    assign bu_result = m_r[LAT-1];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    typedef struct { logic [3:0] oh; logic [31:0] r; int due; } sb_t;
    sb_t sb[$];

    logic        mon_on = 1'b0;
    logic [3:0]  mon_exp;
    logic [31:0] mon_r;
    logic        mon_hit;
    always @(negedge clk) begin
        if (mon_on) begin
            mon_exp = '0;
            mon_r   = '0;
            mon_hit = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_exp = sb[0].oh;
                mon_r   = sb[0].r;
                mon_hit = 1'b1;
                void'(sb.pop_front());
            end
            chk("resp_valid", 64'(resp_valid), 64'(mon_exp));
            if (mon_hit) chk("resp_r", 64'(resp_r), 64'(mon_r));
        end
    end

    typedef struct { logic [3:0] v; logic [3:0][31:0] x; logic [3:0] eg; logic [31:0] er; } vec_t;
    vec_t vt[$];

    function automatic void add(input logic [3:0] v, input logic [3:0][31:0] x,
                                input logic [3:0] eg, input logic [31:0] er);
        vt.push_back(vec_t'{v, x, eg, er});
    endfunction

    // Apply one cycle of requests; called just after a rising edge.
    task automatic step(input logic [3:0] v, input logic [3:0][31:0] x,
                        input logic [3:0] eg, input logic [31:0] er);
        req_valid = v;
        req_x     = x;
        @(negedge clk);
        chk("grant", 64'(req_ready), 64'(eg));
        if (eg != 4'b0) sb.push_back(sb_t'{eg, er, cyc + 1 + LAT});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0, '0, 4'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        int n;
        logic [3:0][31:0] x3;
        x3 = {32'h007F_E000, 32'h0, 32'h007F_E001, 32'h0};

        // round robin with all four valid, from reset
        add(4'hF, {4{32'h0000_0005}}, 4'b0001, 32'h0000_0005);
        add(4'hF, {4{32'h007F_E001}}, 4'b0010, 32'h0000_0000);
        add(4'hF, {4{32'h007F_E002}}, 4'b0100, 32'h0000_0001);
        add(4'hF, {4{32'h00FF_C002}}, 4'b1000, 32'h0000_0000);
        add(4'hF, {4{32'h0100_0000}}, 4'b0001, 32'h0000_3FFE);
        add(4'hF, {4{32'hFFFF_FFFF}}, 4'b0010, 32'h003F_FDFF);
        add(4'hF, {4{32'h007F_E000}}, 4'b0100, 32'h007F_E000);
        add(4'hF, {4{32'h0080_0000}}, 4'b1000, 32'h0000_1FFF);
        add(4'h0, '0, 4'b0, 32'h0);
        // single request on requester 0
        add(4'b0001, {32'h0, 32'h0, 32'h0, 32'h0080_0000}, 4'b0001, 32'h0000_1FFF);
        add(4'h0, '0, 4'b0, 32'h0);
        // requesters 1 and 3 alternate
        add(4'b1010, x3, 4'b0010, 32'h0);
        add(4'b1010, x3, 4'b1000, 32'h007F_E000);
        add(4'b1010, x3, 4'b0010, 32'h0);
        add(4'b1010, x3, 4'b1000, 32'h007F_E000);
        // lone requester granted back to back
        add(4'b0100, {32'h0, 32'h007F_E002, 32'h0, 32'h0}, 4'b0100, 32'h1);
        add(4'b0100, {32'h0, 32'h0000_0002, 32'h0, 32'h0}, 4'b0100, 32'h2);
        // wrap-around priority from last=2
        add(4'b0011, {32'h0, 32'h0, 32'h00FF_C001, 32'h9}, 4'b0001, 32'h9);
        add(4'b0011, {32'h0, 32'h0, 32'h00FF_C001, 32'h9}, 4'b0010, 32'h007F_E000);

        rst = 1'b1; drain = 1'b0; spur = 1'b0;
        req_valid = 4'hF; req_x = '0;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_resp", 64'(resp_valid), 64'h0);
        chk("rst_start", 64'(bu_start), 64'h0);
        chk("rst_bu_x", 64'(bu_x), 64'h0);
        chk("rst_drained", 64'(drained), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("const_q", 64'(bu_q), 64'h7FE001);
        chk("const_q_bl", 64'(bu_q_bl), 64'd23);
        chk("const_mu", 64'(bu_mu), 64'h802007);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        mon_on = 1'b1;

        foreach (vt[i]) step(vt[i].v, vt[i].x, vt[i].eg, vt[i].er);
        idle(LAT + 2);
        chk("sb_empty_table", 64'(sb.size()), 64'h0);

        // drain with three operations in flight
        step(4'b0100, {32'h0, 32'h3, 32'h0, 32'h0}, 4'b0100, 32'h3);
        step(4'b0100, {32'h0, 32'h4, 32'h0, 32'h0}, 4'b0100, 32'h4);
        step(4'b0100, {32'h0, 32'h5, 32'h0, 32'h0}, 4'b0100, 32'h5);
        drain = 1'b1; req_valid = 4'hF;
        @(negedge clk);
        chk("drain_ready_now", 64'(req_ready), 64'h0);
        chk("drain_not_yet", 64'(drained), 64'h0);
        n = 0;
        while (drained !== 1'b1 && n < 20) begin
            @(negedge clk);
            chk("drain_ready", 64'(req_ready), 64'h0);
            n++;
        end
        chk("drained_seen", 64'(drained), 64'h1);
        chk("drain_after_retire", 64'(sb.size()), 64'h0);
        @(posedge clk); #1;
        chk("halt_hold", 64'(drained), 64'h1);
        chk("halt_ready", 64'(req_ready), 64'h0);
        drain = 1'b0; req_valid = '0;
        @(posedge clk); #1;
        chk("resume_drained", 64'(drained), 64'h0);
        step(4'b0001, {32'h0, 32'h0, 32'h0, 32'h007F_E003}, 4'b0001, 32'h2);
        idle(LAT + 2);

        // reset with four operations in flight
        step(4'hF, {4{32'h10}}, 4'b0010, 32'h10);
        step(4'hF, {4{32'h11}}, 4'b0100, 32'h11);
        step(4'hF, {4{32'h12}}, 4'b1000, 32'h12);
        step(4'hF, {4{32'h13}}, 4'b0001, 32'h13);
        rst = 1'b1; req_valid = 4'hF;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_resp", 64'(resp_valid), 64'h0);
        chk("mid_rst_start", 64'(bu_start), 64'h0);
        chk("mid_rst_bu_x", 64'(bu_x), 64'h0);
        chk("mid_rst_drained", 64'(drained), 64'h0);
        chk("mid_rst_err", 64'(err), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0;
        idle(LAT + 2);
        step(4'hF, {4{32'h20}}, 4'b0001, 32'h20);
        idle(LAT + 2);
        chk("sb_empty_final", 64'(sb.size()), 64'h0);

        // spurious unit valid
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err), 64'(EXP_ERR));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_hold", 64'(err), 64'(EXP_ERR));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/barrett_sched.md
# barrett_sched

Round-robin scheduler that shares one `barrett_pipelined` reduction unit among `NUM_REQ` requesters. It accepts one operand per cycle through a valid/ready handshake and issues it to the unit with the fixed modulus constants. It tags every in-flight operation with its requester ID in a delay line matched to the unit latency, then steers each result back to its owner. It sits between the NTT/polynomial datapath clients and the single reduction core, and supports a drain handshake for quiescing before reconfiguration or reset.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `LATENCY`, default 5: cycles from the unit's `start_i` to its `valid_o`.

Ports:
- `clk_i`, in, 1: clock; rising edge active.
- `rst_i`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `req_valid_i`, in, `NUM_REQ`: per-requester operand valid.
- `req_x_i`, in, `NUM_REQ`×`DATA_LENGTH`: per-requester operand x.
- `req_ready_o`, out, `NUM_REQ`: one-hot grant, accepted when valid&&ready.
- `resp_valid_o`, out, `NUM_REQ`: one-hot result strobe. There is no backpressure.
- `resp_r_o`, out, `DATA_LENGTH`: shared result bus.
- `bu_start_o`, out, 1: unit start.
- `bu_x_o`, out, `DATA_LENGTH`: unit operand.
- `bu_q_o`, `bu_q_bl_o`, `bu_mu_o`, out, `DATA_LENGTH` each: driven constant `MODULUS`, `MODULUS_LENGTH`, `MU`.
- `bu_result_i`, in, `DATA_LENGTH`: unit result.
- `bu_valid_i`, in, 1: unit result valid.
- `drain_i`, in, 1: request quiesce.
- `drained_o`, out, 1: no work accepted and none in flight.
- `err_o`, out, 1: sticky protocol error.

## Operation
- FSM states RUN, DRAIN, HALTED. Reset state is RUN.
  - RUN→DRAIN when `drain_i`=1.
  - DRAIN→HALTED when the in-flight count is 0 and `bu_start_o`=0.
  - HALTED→RUN when `drain_i`=0.
  - DRAIN→RUN is not allowed. Once entered, drain always completes.
- Grants:
  - In RUN, `req_ready_o` is the round-robin choice among the asserted `req_valid_i`. Priority starts at `last+1` mod `NUM_REQ`, where `last` is the most recently granted index.
  - `last` updates only on acceptance. Its reset value is `NUM_REQ-1`, so index 0 wins first.
  - `req_ready_o` depends combinationally on `req_valid_i`. It is all-zero outside RUN and while `rst_i` is high.
- Issue:
  - On acceptance at edge k, `bu_start_o`=1 and `bu_x_o`=x in the following cycle.
  - `bu_x_o` holds its last value when `bu_start_o`=0.
- Tag line:
  - `LATENCY`-deep shift register of {valid, id}, where id is `$clog2(NUM_REQ)` bits.
  - Loaded with {`bu_start_o`, granted id} and shifted every cycle.
- Response:
  - `resp_valid_o[id]` = tail.valid.
  - `resp_r_o` = `bu_result_i` combinationally; it is undefined when no strobe is asserted.
- In-flight counter, width `$clog2(LATENCY+2)`: +1 on issue, −1 on tail.valid. Simultaneous issue and retire leave it unchanged.
- `drained_o` = (state==HALTED).

## Timing
- Throughput: 1 operation per cycle. Back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Latency from acceptance edge to `resp_valid_o`: `LATENCY`+1 cycles.
- Reset values: `req_ready_o` 0, `resp_valid_o` 0, `bu_start_o` 0, `bu_x_o` 0, tag line cleared, counter 0, `drained_o` 0, `err_o` 0.
- Reset asserted mid-operation discards every in-flight tag; the scheduler ignores unit results after reset.
- A requester is never starved: with all requesters valid, it waits at most `NUM_REQ`-1 cycles.

## Configuration
- `BARRETT_SCHED_CHECK_EN` defined: `err_o` sets and stays set until reset on either of:
  - `bu_valid_i` ≠ tail.valid in any cycle;
  - tail.valid && `bu_result_i` ≥ `MODULUS`.
- `BARRETT_SCHED_CHECK_EN` undefined: `err_o` is tied 0. `bu_valid_i` is unused and no comparator logic is built.

## Structure
- `params_pkg` gains `NUM_REQ` and `SCHED_LATENCY` defaults, plus the `req_id_t` typedef.
- The `sched_state_e` enum belongs in `multiplier_pkg`, next to the existing datapath types.
- Sub-module `rr_arbiter`:
  - inputs: request vector, accept, enable;
  - outputs: one-hot grant and encoded index;
  - owns the `last` pointer.
- The tag line, counter and FSM stay in `barrett_sched`.

## Test plan
- Single request, requester 0, x=0x00800000 → `resp_valid_o`=0001 six cycles after acceptance, `resp_r_o`=0x00001FFF (q=0x7FE001).
- All four requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Results return in the same order, each matching x mod q.
- Requesters 1 and 3 only, x=0x7FE001 and x=0x7FE000 → alternating grants 1,3. Results 0x0 and 0x7FE000.
- `drain_i` raised with 3 operations in flight → ready drops the same cycle, `drained_o` rises once the third result retires, and RUN resumes after `drain_i` falls.
- `rst_i` pulsed with 4 operations in flight → no `resp_valid_o` afterwards and all outputs at reset values. The first post-reset grant goes to index 0.
- With `BARRETT_SCHED_CHECK_EN`, force a spurious `bu_valid_i` → `err_o`=1 the next cycle and stays set until reset.
